// File: rtl/instr_issue_unit.sv
// -----------------------------------------------------------------------------
// instr_issue_unit
//
// Instruction source and RAW-hazard interlock for the three-stage pipeline
// datapath. Holds a small program memory, streams one 32-bit slot per cycle
// (a real instruction or a bubble), drains the pipeline with three bubbles
// after the last instruction, then pulses Done.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   LoadEn       write LoadData to mem[LoadAddr] (ignored while Busy)
//   LoadAddr     program memory write address
//   LoadData     instruction word to store
//   ProgLen      number of instructions to run (0..DEPTH), sampled with Start
//   Start        begin a run (only honoured in IDLE)
//   InstrOut     registered instruction slot (0 for a bubble)
//   WriteEnable  1 for a real instruction, 0 for a bubble
//   Busy         run in progress
//   Done         one-cycle completion pulse
//   PC           index of the next instruction to issue
//   StallCount   hazard bubbles inserted this run, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module instr_issue_unit #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WINDOW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [31:0]       LoadData,
  input  logic [ADDR_W:0]   ProgLen,
  input  logic              Start,
  output logic [31:0]       InstrOut,
  output logic              WriteEnable,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   PC,
  output logic [15:0]       StallCount
);

  localparam logic [ADDR_W:0] PC_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]             mem [DEPTH];
  logic [ADDR_W:0]         prog_len;
  logic [1:0]              drain_cnt;
  logic [WINDOW-1:0][4:0]  hist_rd;
  logic [WINDOW-1:0]       hist_vld;

  logic [31:0] cand;
  logic [4:0]  cand_rd;
  logic [4:0]  cand_rs;
  logic [4:0]  cand_rt;
  logic        cand_imm;
  logic        hazard;
  logic        last_issue;
  logic [4:0]  shift_rd;
  logic        shift_vld;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // Program memory: write port gated by Busy, asynchronous read at PC.
  // A load in the same cycle as Start lands before the first read one edge later.
  always_ff @(posedge clk) begin
    if (LoadEn && !Busy)
      mem[LoadAddr] <= LoadData;
  end

  assign cand     = mem[PC[ADDR_W-1:0]];
  assign cand_rd  = cand[25:21];
  assign cand_rs  = cand[20:16];
  assign cand_rt  = cand[15:11];
  assign cand_imm = cand[29];

  assign last_issue = ((PC + PC_ONE) == prog_len);

  // rt only counts as a source when the immediate is not selected.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WINDOW; i++) begin
      if (hist_vld[i] &&
          ((hist_rd[i] == cand_rs) || (!cand_imm && (hist_rd[i] == cand_rt))))
        hazard = 1'b1;
    end
  end

  // Every cycle shifts one entry into the history; anything other than an
  // issued instruction is a bubble, so the window naturally empties between runs.
  always_comb begin
    shift_vld = 1'b0;
    shift_rd  = 5'd0;
    if (state == S_ISSUE && !hazard) begin
      shift_vld = 1'b1;
      shift_rd  = cand_rd;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = (ProgLen != '0) ? S_ISSUE : S_DONE;
      S_ISSUE: if (!hazard && last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == 2'd2) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Slot register stage: outputs registered from current state and candidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      prog_len    <= '0;
      drain_cnt   <= 2'd0;
      PC          <= '0;
      StallCount  <= 16'd0;
      InstrOut    <= 32'd0;
      WriteEnable <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      hist_rd     <= '0;
      hist_vld    <= '0;
    end else begin
      state <= state_nxt;
      // Busy rises with the Start edge but stays up through the edge that
      // emits the last drain bubble, so it covers every slot of the run.
      Busy  <= (state_nxt == S_ISSUE) || (state_nxt == S_DRAIN) || (state == S_DRAIN);
      Done  <= (state == S_DONE);

      InstrOut    <= 32'd0;
      WriteEnable <= 1'b0;

      hist_rd[0]  <= shift_rd;
      hist_vld[0] <= shift_vld;
      for (int i = 1; i < WINDOW; i++) begin
        hist_rd[i]  <= hist_rd[i-1];
        hist_vld[i] <= hist_vld[i-1];
      end

      case (state)
        S_IDLE: begin
          if (Start) begin
            prog_len   <= ProgLen;
            PC         <= '0;
            StallCount <= 16'd0;
          end
        end
        S_ISSUE: begin
          if (hazard) begin
            StallCount <= sat_inc16(StallCount);
          end else begin
            InstrOut    <= cand;
            WriteEnable <= 1'b1;
            PC          <= PC + PC_ONE;
            drain_cnt   <= 2'd0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
